// File: rtl/onehot_hold_decoder.sv
// rtl/onehot_hold_decoder.sv - encoded index to held, handshaked one-hot lane select
//
// Accepts an encoded index on a valid/ready input, registers its decoded
// vector, keeps it stable for HOLD_CYC cycles and then offers it downstream
// with valid/ready. One index is in flight at a time.
//
// Build option: DECODE_THERMO_EN selects thermometer decode (all lanes at or
// below the index) instead of one-hot decode.
//
// Parameters:
//   IDX_W     index width; output width N = 2**IDX_W
//   HOLD_CYC  cycles out_vec is driven before out_valid rises (0..255)
//
// Ports:
//   clk        input   clock, rising edge
//   rst        input   asynchronous active-high reset
//   in_valid   input   index available
//   in_ready   output  decoder idle and able to accept an index
//   in_idx     input   [IDX_W-1:0] encoded index, 0 = LSB lane
//   in_en      input   0 = no lane, decodes to the all-zero vector
//   out_vec    output  [N-1:0] decoded vector, registered
//   out_valid  output  out_vec final and offered downstream
//   out_ready  input   downstream accepts out_vec
//   busy       output  decoder not idle

module onehot_hold_decoder #(
  parameter int IDX_W    = 2,
  parameter int HOLD_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_en,
  output logic [(2**IDX_W)-1:0] out_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int N = 2 ** IDX_W;
  // A zero hold period still needs a legal one-bit counter; it is never loaded.
  localparam int CNT_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [N-1:0]     vec, vec_nx;

  function automatic logic [N-1:0] decode(input logic [IDX_W-1:0] idx, input logic en);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
`ifdef DECODE_THERMO_EN
      v[i] = en && (i <= int'(idx));
`else
      v[i] = en && (i == int'(idx));
`endif
    end
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      vec   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      vec   <= vec_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    vec_nx   = vec;
    case (state)
      S_IDLE: begin
        // in_idx/in_en are captured only here; later changes are ignored.
        if (in_valid) begin
          vec_nx = decode(in_idx, in_en);
          if (HOLD_CYC > 0) begin
            state_nx = S_HOLD;
            cnt_nx   = CNT_LOAD;
          end else begin
            state_nx = S_PRESENT;
          end
        end
      end
      S_HOLD: begin
        // out_ready is deliberately not looked at while holding.
        if (cnt == '0) begin
          state_nx = S_PRESENT;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          vec_nx   = '0;
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        vec_nx   = '0;
      end
    endcase
  end

  // Handshake outputs come straight from the state register so they follow
  // an asynchronous reset immediately.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_PRESENT);
  assign busy      = (state != S_IDLE);
  assign out_vec   = vec;

endmodule

// File: tb/tb_onehot_hold_decoder.sv
// tb/tb_onehot_hold_decoder.sv - directed self-checking bench for onehot_hold_decoder

module tb_onehot_hold_decoder;

`ifdef DECODE_THERMO_EN
  localparam logic [3:0] V0 = 4'b0001;
  localparam logic [3:0] V1 = 4'b0011;
  localparam logic [3:0] V2 = 4'b0111;
  localparam logic [3:0] V3 = 4'b1111;
`else
  localparam logic [3:0] V0 = 4'b0001;
  localparam logic [3:0] V1 = 4'b0010;
  localparam logic [3:0] V2 = 4'b0100;
  localparam logic [3:0] V3 = 4'b1000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_idx = 2'd0;
  logic       in_en = 1'b0;
  logic [3:0] out_vec;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;

  logic       in_valid_z = 1'b0;
  logic       in_ready_z;
  logic [1:0] in_idx_z = 2'd0;
  logic       in_en_z = 1'b0;
  logic [3:0] out_vec_z;
  logic       out_valid_z;
  logic       out_ready_z = 1'b0;
  logic       busy_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_hold_decoder #(.IDX_W(2), .HOLD_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_en(in_en),
    .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  onehot_hold_decoder #(.IDX_W(2), .HOLD_CYC(0)) dut_z (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_z), .in_ready(in_ready_z), .in_idx(in_idx_z), .in_en(in_en_z),
    .out_vec(out_vec_z), .out_valid(out_valid_z), .out_ready(out_ready_z), .busy(busy_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (out_vec !== 4'b0000) begin errors++; $display("FAIL reset_out_vec got %b want %b", out_vec, 4'b0000); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_all_indices();
    logic [3:0] exp_tab [4];
    int lat;
    int w;
    exp_tab = '{V0, V1, V2, V3};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_idx = i[1:0];
      in_en = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_vec !== exp_tab[i]) begin errors++; $display("FAIL idx%0d_vec_at_accept got %b want %b", i, out_vec, exp_tab[i]); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idx%0d_in_ready_after_accept got %b want 0", i, in_ready); end
      lat = 0;
      while (!out_valid && lat < 10) begin tick(); lat++; end
      checks++; if (lat !== 2) begin errors++; $display("FAIL idx%0d_valid_latency got %0d want 2", i, lat); end
      checks++; if (out_vec !== exp_tab[i]) begin errors++; $display("FAIL idx%0d_vec_presented got %b want %b", i, out_vec, exp_tab[i]); end
      w = 0;
      while (!in_ready && w < 10) begin tick(); w++; end
      // accept edge to the next edge that can accept again
      checks++; if (lat + w + 1 !== 4) begin errors++; $display("FAIL idx%0d_accept_period got %0d want 4", i, lat + w + 1); end
      checks++; if (out_vec !== 4'b0000) begin errors++; $display("FAIL idx%0d_vec_cleared got %b want 0000", i, out_vec); end
    end
  endtask

  task automatic test_zero_vector();
    int lat;
    out_ready = 1'b0;
    in_idx = 2'd3;
    in_en = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_vec !== 4'b0000) begin errors++; $display("FAIL zero_vec got %b want 0000", out_vec); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got %b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < 10) begin tick(); lat++; end
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_valid_latency got %0d want 2", lat); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_waits_for_ready got %b want 1", out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_complete got in_ready=%b busy=%b want 1 0", in_ready, busy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_idx = 2'd1;
    in_en = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_idx = 2'd2;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_vec !== V1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_c%0d got vec=%b valid=%b want %b 1", c, out_vec, out_valid, V1); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_accept_c%0d got in_ready=%b want 0", c, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_vec !== 4'b0000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_transfer got vec=%b valid=%b in_ready=%b want 0000 0 1", out_vec, out_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_vec !== V2 || busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept got vec=%b busy=%b want %b 1", out_vec, busy, V2); end
    tick();
    tick();
    tick();
    checks++; if (in_ready !== 1'b1 || out_vec !== 4'b0000) begin errors++; $display("FAIL bp_drain got in_ready=%b vec=%b want 1 0000", in_ready, out_vec); end
  endtask

  task automatic test_churn();
    out_ready = 1'b1;
    in_idx = 2'd2;
    in_en = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_idx = 2'd0;
    in_en = 1'b0;
    tick();
    checks++; if (out_vec !== V2) begin errors++; $display("FAIL churn_hold0 got %b want %b", out_vec, V2); end
    in_idx = 2'd3;
    in_en = 1'b1;
    tick();
    checks++; if (out_vec !== V2 || out_valid !== 1'b1) begin errors++; $display("FAIL churn_present got vec=%b valid=%b want %b 1", out_vec, out_valid, V2); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL churn_done got in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_hold_zero();
    out_ready_z = 1'b0;
    in_idx_z = 2'd2;
    in_en_z = 1'b1;
    in_valid_z = 1'b1;
    tick();
    in_valid_z = 1'b0;
    checks++; if (out_vec_z !== V2) begin errors++; $display("FAIL h0_vec got %b want %b", out_vec_z, V2); end
    checks++; if (out_valid_z !== 1'b1) begin errors++; $display("FAIL h0_valid got %b want 1", out_valid_z); end
    tick();
    checks++; if (out_valid_z !== 1'b1 || out_vec_z !== V2) begin errors++; $display("FAIL h0_hold got valid=%b vec=%b want 1 %b", out_valid_z, out_vec_z, V2); end
    out_ready_z = 1'b1;
    tick();
    checks++; if (out_valid_z !== 1'b0 || in_ready_z !== 1'b1) begin errors++; $display("FAIL h0_done got valid=%b in_ready=%b want 0 1", out_valid_z, in_ready_z); end
  endtask

  task automatic test_reset_mid_present();
    out_ready = 1'b0;
    in_idx = 2'd3;
    in_en = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b1 || out_vec !== V3) begin errors++; $display("FAIL rmp_setup got valid=%b vec=%b want 1 %b", out_valid, out_vec, V3); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_vec !== 4'b0000) begin errors++; $display("FAIL rmp_vec got %b want 0000", out_vec); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmp_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmp_ready_busy got in_ready=%b busy=%b want 1 0", in_ready, busy); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmp_after got valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_all_indices();
    test_zero_vector();
    test_backpressure();
    test_churn();
    test_hold_zero();
    test_reset_mid_present();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
